// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants and slave FSM state encoding
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  // R/W bit that follows the 7-bit address
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - pad synchronizer with optional glitch filter
// Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (all flops reset to line-idle 1)
//   i_line   raw pad input
//   o_line   synchronized (and, with the macro, filtered) line level
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_line
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // Output follows only after FILTER_LEN consecutive clocks at the new level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      filt_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_line = filt_q;
`else
  assign o_line = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target, 7-bit address, 8-bit single-cycle byte interface
// Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN (glitch filter on SCL/SDA)
// Ports:
//   i_clk, i_rst_n   system clock (>= 8x SCL), asynchronous active-low reset
//   i_scl, i_sda     pad inputs
//   o_sda_oe         1 = pull SDA low
//   o_wr_valid       one-cycle pulse, o_wr_data holds a received byte
//   o_wr_data        last received data byte
//   o_rd_req         one-cycle pulse, i_rd_data sampled on the following cycle
//   i_rd_data        byte to transmit
//   o_busy           addressed and transfer in progress
//   o_nack_seen      sticky master NACK of a read byte, cleared by START
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h21,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_oe,
  output logic                  o_wr_valid,
  output logic [I2C_DATA_W-1:0] o_wr_data,
  output logic                  o_rd_req,
  input  logic [I2C_DATA_W-1:0] i_rd_data,
  output logic                  o_busy,
  output logic                  o_nack_seen
);

  logic s_scl, s_sda, scl_q, sda_q;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_line(i_scl), .o_line(s_scl)
  );
  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_line(i_sda), .o_line(s_sda)
  );

  // START/STOP need SCL high in both cycles, so an SDA edge coinciding
  // with an SCL edge is treated as an ordinary data change.
  logic start_det, stop_det, scl_rise, scl_fall;
  assign start_det = scl_q & s_scl & sda_q & ~s_sda;
  assign stop_det  = scl_q & s_scl & ~sda_q & s_sda;
  assign scl_rise  = ~scl_q & s_scl;
  assign scl_fall  = scl_q & ~s_scl;

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_DATA_W-1:0] shift_q, shift_d, wr_data_q, wr_data_d;
  // ACK states: 1 = ACK currently driven. RD_BYTE: 1 = MSB still to drive.
  logic                  phase_q, phase_d;
  logic                  rw_q, rw_d;
  logic                  sda_oe_q, sda_oe_d, busy_q, busy_d, nack_q, nack_d;
  logic                  wr_valid_q, wr_valid_d, rd_req_q, rd_req_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= '0;
      wr_data_q  <= '0;
      phase_q    <= 1'b0;
      rw_q       <= RW_WRITE;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      scl_q      <= s_scl;
      sda_q      <= s_sda;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wr_data_q  <= wr_data_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wr_data_d  = wr_data_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    nack_d     = nack_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;

    // Transmit byte arrives the cycle after the request.
    if (rd_req_q) shift_d = i_rd_data;

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 3'd7;
      phase_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      nack_d    = 1'b0;
      bit_cnt_d = 3'd7;
      phase_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = {shift_q[I2C_DATA_W-2:0], s_sda};
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d = 3'd7;
            phase_d   = 1'b0;
            // General call (address 0) is never acknowledged.
            if (shift_q[I2C_ADDR_W-1:0] == SLAVE_ADDR && SLAVE_ADDR != '0) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = s_sda;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (state_q == WR_ACK || rw_q == RW_WRITE) begin
                state_d  = WR_BYTE;
                sda_oe_d = 1'b0;
              end else begin
                // ACK release and read MSB share this falling edge.
                state_d   = RD_BYTE;
                sda_oe_d  = ~shift_q[I2C_DATA_W-1];
                shift_d   = {shift_q[I2C_DATA_W-2:0], 1'b0};
                bit_cnt_d = 3'd7;
              end
            end
          end else if (scl_rise && phase_q && state_q == ADDR_ACK && rw_q == RW_READ) begin
            rd_req_d = 1'b1;
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_d = {shift_q[I2C_DATA_W-2:0], s_sda};
          if (bit_cnt_q == 3'd0) begin
            wr_valid_d = 1'b1;
            wr_data_d  = {shift_q[I2C_DATA_W-2:0], s_sda};
            state_d    = WR_ACK;
            bit_cnt_d  = 3'd7;
            phase_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        RD_BYTE: if (scl_fall) begin
          if (phase_q || bit_cnt_q != 3'd0) begin
            sda_oe_d = ~shift_q[I2C_DATA_W-1];
            shift_d  = {shift_q[I2C_DATA_W-2:0], 1'b0};
            if (phase_q) phase_d = 1'b0;
            else         bit_cnt_d = bit_cnt_q - 3'd1;
          end else begin
            sda_oe_d  = 1'b0;
            state_d   = RD_ACK;
            bit_cnt_d = 3'd7;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!s_sda) begin
            rd_req_d  = 1'b1;
            state_d   = RD_BYTE;
            phase_d   = 1'b1;
            bit_cnt_d = 3'd7;
          end else begin
            nack_d  = 1'b1;
            state_d = IGNORE;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign o_sda_oe    = sda_oe_q;
  assign o_wr_valid  = wr_valid_q;
  assign o_wr_data   = wr_data_q;
  assign o_rd_req    = rd_req_q;
  assign o_busy      = busy_q;
  assign o_nack_seen = nack_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - self-checking bench for i2c_slave with a bus-level master model
module tb_i2c_slave;

  localparam int Q = 6;                 // clocks per quarter SCL period
  localparam logic [6:0] OWN = 7'h21;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       i_scl, i_sda;
  logic [7:0] i_rd_data = 8'h00;
  logic       o_sda_oe, o_wr_valid, o_rd_req, o_busy, o_nack_seen;
  logic [7:0] o_wr_data;

  assign i_scl = scl_m;
  assign i_sda = sda_m & ~o_sda_oe;     // open-drain wired-AND

  always #5 i_clk = ~i_clk;

  i2c_slave dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_scl(i_scl), .i_sda(i_sda),
    .o_sda_oe(o_sda_oe), .o_wr_valid(o_wr_valid), .o_wr_data(o_wr_data),
    .o_rd_req(o_rd_req), .i_rd_data(i_rd_data), .o_busy(o_busy),
    .o_nack_seen(o_nack_seen)
  );

  int n_pass = 0, n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bus monitors and read-data supplier
  logic [7:0] wr_got[$];
  logic [7:0] rd_src[$];
  int         rd_req_cnt = 0;
  int         busy_low = 0;
  bit         watch_busy = 1'b0;

  always @(negedge i_clk) begin
    if (o_wr_valid) wr_got.push_back(o_wr_data);
    if (o_rd_req) begin
      rd_req_cnt++;
      i_rd_data = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hFF;
    end
    if (watch_busy && !o_busy) busy_low++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Master bus-functional model
  task automatic qd(); repeat (Q) @(negedge i_clk); endtask
  task automatic bus_start(); sda_m = 1; qd(); scl_m = 1; qd(); sda_m = 0; qd(); scl_m = 0; qd(); endtask
  task automatic bus_stop(); sda_m = 0; qd(); scl_m = 1; qd(); sda_m = 1; qd(); repeat (6) @(negedge i_clk); endtask
  task automatic wr_bit(input logic b); sda_m = b; qd(); scl_m = 1; qd(); qd(); scl_m = 0; qd(); endtask
  task automatic rd_bit(output logic b); sda_m = 1; qd(); scl_m = 1; qd(); b = i_sda; qd(); scl_m = 0; qd(); endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    ack = ~a;
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic ack_it);
    logic b;
    for (int i = 7; i >= 0; i--) begin rd_bit(b); d[i] = b; end
    wr_bit(~ack_it);
  endtask

  // One complete transaction; payload in tx_q, read results in rx_q
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         data_nacks;

  task automatic do_txn(input logic [6:0] addr, input logic rw, output logic ack);
    logic a;
    logic [7:0] d;
    rx_q.delete(); wr_got.delete(); rd_req_cnt = 0; data_nacks = 0;
    rd_src = tx_q;
    bus_start();
    wr_byte({addr, rw}, ack);
    if (ack) begin
      for (int i = 0; i < tx_q.size(); i++) begin
        if (!rw) begin wr_byte(tx_q[i], a); if (!a) data_nacks++; end
        else begin rd_byte(d, i < tx_q.size() - 1); rx_q.push_back(d); end
      end
    end
    bus_stop();
    rd_src.delete();
  endtask

  // Reference model: a transaction is a list of bytes; the target accepts
  // it iff the address is its own, writes appear one-for-one on the byte
  // port, reads return the supplied list, one request per byte, and the
  // final master NACK leaves the sticky flag set.
  task automatic run_and_check(input string tag, input logic [6:0] addr, input logic rw);
    logic ack, exp_ack;
    exp_ack = (addr == OWN);
    do_txn(addr, rw, ack);
    check({tag, " addr_ack"}, 32'(ack), 32'(exp_ack));
    if (!rw) begin
      check({tag, " wr_count"}, wr_got.size(), exp_ack ? tx_q.size() : 0);
      for (int i = 0; i < wr_got.size() && i < tx_q.size(); i++)
        check($sformatf("%s wr_data[%0d]", tag, i), 32'(wr_got[i]), 32'(tx_q[i]));
      check({tag, " data_nacks"}, data_nacks, 0);
    end else begin
      check({tag, " rd_req_count"}, rd_req_cnt, exp_ack ? tx_q.size() : 0);
      if (exp_ack)
        for (int i = 0; i < rx_q.size(); i++)
          check($sformatf("%s rd_data[%0d]", tag, i), 32'(rx_q[i]), 32'(tx_q[i]));
    end
    check({tag, " busy_after_stop"}, 32'(o_busy), 0);
    check({tag, " oe_after_stop"}, 32'(o_sda_oe), 0);
    check({tag, " nack_seen"}, 32'(o_nack_seen), 32'(rw & exp_ack));
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    int         n;
    logic [7:0] d0;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic ack, b;
    logic [7:0] d;

    vecs[0] = '{7'h21, 1'b0, 1, 8'hA5, 1'b1};
    vecs[1] = '{7'h21, 1'b1, 1, 8'h3C, 1'b1};
    vecs[2] = '{7'h22, 1'b0, 1, 8'h11, 1'b0};
    vecs[3] = '{7'h00, 1'b0, 1, 8'h00, 1'b0};
    vecs[4] = '{7'h21, 1'b0, 3, 8'hF0, 1'b1};
    vecs[5] = '{7'h21, 1'b1, 3, 8'h55, 1'b1};
    vecs[6] = '{7'h20, 1'b1, 1, 8'h99, 1'b0};
    vecs[7] = '{7'h61, 1'b0, 1, 8'h42, 1'b0};

    repeat (4) @(negedge i_clk);
    check("rst sda_oe", 32'(o_sda_oe), 0);
    check("rst wr_valid", 32'(o_wr_valid), 0);
    check("rst wr_data", 32'(o_wr_data), 0);
    check("rst rd_req", 32'(o_rd_req), 0);
    check("rst busy", 32'(o_busy), 0);
    check("rst nack_seen", 32'(o_nack_seen), 0);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);

    // Table-driven transactions
    foreach (vecs[k]) begin
      tx_q.delete();
      for (int i = 0; i < vecs[k].n; i++) tx_q.push_back(vecs[k].d0 + 8'(i * 37));
      do_txn(vecs[k].addr, vecs[k].rw, ack);
      check($sformatf("vec%0d ack", k), 32'(ack), 32'(vecs[k].exp_ack));
      if (vecs[k].rw)
        check($sformatf("vec%0d rd_reqs", k), rd_req_cnt, vecs[k].exp_ack ? vecs[k].n : 0);
      else
        check($sformatf("vec%0d wr_count", k), wr_got.size(), vecs[k].exp_ack ? vecs[k].n : 0);
      if (vecs[k].exp_ack && vecs[k].rw)
        check($sformatf("vec%0d first_rd", k), 32'(rx_q[0]), 32'(vecs[k].d0));
      if (vecs[k].exp_ack && !vecs[k].rw && wr_got.size() > 0)
        check($sformatf("vec%0d first_wr", k), 32'(wr_got[0]), 32'(vecs[k].d0));
      check($sformatf("vec%0d busy", k), 32'(o_busy), 0);
    end

    // Randomized transactions against the reference model
    for (int t = 0; t < 10; t++) begin
      logic [6:0] a;
      logic rw;
      a  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : OWN;
      rw = 1'($urandom_range(0, 1));
      tx_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) tx_q.push_back(8'($urandom));
      run_and_check($sformatf("rnd%0d", t), a, rw);
    end

    // Repeated START: write 0x10, then read without an intervening STOP
    tx_q.delete(); rd_src.delete(); rd_src.push_back(8'hC3);
    wr_got.delete(); rd_req_cnt = 0; busy_low = 0;
    bus_start();
    wr_byte({OWN, 1'b0}, ack);
    watch_busy = 1'b1;
    wr_byte(8'h10, ack);
    check("rs wr_data", 32'(o_wr_data), 32'h10);
    bus_start();
    wr_byte({OWN, 1'b1}, ack);
    check("rs read ack", 32'(ack), 1);
    rd_byte(d, 1'b0);
    watch_busy = 1'b0;
    check("rs read data", 32'(d), 32'hC3);
    check("rs busy held", busy_low, 0);
    check("rs nack_seen", 32'(o_nack_seen), 1);
    bus_start();
    repeat (6) @(negedge i_clk);
    check("start clears nack_seen", 32'(o_nack_seen), 0);
    wr_byte({7'h33, 1'b0}, ack);
    bus_stop();
    check("rs final busy", 32'(o_busy), 0);

    // STOP after four data bits discards the partial byte
    wr_got.delete();
    bus_start();
    wr_byte({OWN, 1'b0}, ack);
    for (int i = 0; i < 4; i++) wr_bit(1'b1);
    bus_stop();
    check("partial no wr_valid", wr_got.size(), 0);
    check("partial busy", 32'(o_busy), 0);
    check("partial oe", 32'(o_sda_oe), 0);

    // SCL and SDA falling together is not a START: own address must be ignored
    sda_m = 0; scl_m = 0; qd();
    for (int i = 7; i >= 0; i--) wr_bit(8'(OWN << 1) >> i);
    rd_bit(b);
    check("simul edge no ack", 32'(b), 1);
    bus_stop();

    // Reset while driving a read bit releases SDA asynchronously
    rd_src.delete(); rd_src.push_back(8'h00);
    bus_start();
    wr_byte({OWN, 1'b1}, ack);
    check("rd msb driven", 32'(o_sda_oe), 1);
    i_rst_n = 1'b0;
    #1;
    check("async reset oe", 32'(o_sda_oe), 0);
    repeat (2) @(negedge i_clk);
    scl_m = 1; sda_m = 1;
    repeat (4) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    check("post reset busy", 32'(o_busy), 0);
    rd_src.delete();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-clock SCL glitch mid-byte must not shift an extra bit
    wr_got.delete();
    bus_start();
    wr_byte({OWN, 1'b0}, ack);
    d = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) begin
        sda_m = d[i]; repeat (2) @(negedge i_clk);
        scl_m = 1; @(negedge i_clk); scl_m = 0;
        repeat (Q - 3) @(negedge i_clk);
        scl_m = 1; qd(); qd(); scl_m = 0; qd();
      end else begin
        wr_bit(d[i]);
      end
    end
    rd_bit(b);
    bus_stop();
    check("glitch ack", 32'(b), 0);
    check("glitch wr_count", wr_got.size(), 1);
    if (wr_got.size() > 0) check("glitch wr_data", 32'(wr_got[0]), 32'h5A);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
